// File: rtl/seg_display_ctrl_pkg.sv
// Shared definitions for the seven-segment display controller.
//   SEG_BLANK / SEG_DASH : special active-low gfedcba patterns
//   state_e              : conversion sequencer states
//   digit_to_seg()       : BCD digit -> active-low gfedcba pattern (codes > 9 go dark)
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Display bus between the game logic and the seven-segment controller.
//   val      : N_CHAN packed binary values, channel c at [c*VAL_W +: VAL_W]
//   blank    : per-channel force-dark
//   blink_en : per-channel blink enable
//   seg      : active-low gfedcba, channel c digit d at [(c*DIGITS+d)*7 +: 7]
//   upd_done : one-cycle pulse when a channel's display register is committed
//   upd_chan : channel committed alongside upd_done
// Modports: master = value producer, slave = display controller.
interface seg_display_ctrl_if #(
  parameter int N_CHAN = 4,
  parameter int VAL_W  = 8,
  parameter int DIGITS = 2
);
  localparam int CH_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

  logic [N_CHAN*VAL_W-1:0]    val;
  logic [N_CHAN-1:0]          blank;
  logic [N_CHAN-1:0]          blink_en;
  logic [N_CHAN*DIGITS*7-1:0] seg;
  logic                       upd_done;
  logic [CH_W-1:0]            upd_chan;

  modport master (
    output val, blank, blink_en,
    input  seg, upd_done, upd_chan
  );

  modport slave (
    input  val, blank, blink_en,
    output seg, upd_done, upd_chan
  );

endinterface

// File: rtl/seg_display_ctrl_bin2bcd.sv
// Serial binary-to-BCD converter (shift-add-3 / double dabble).
//   clk, rst  : clock, asynchronous active-high reset
//   start_i   : load bin_i and clear the BCD register (one cycle)
//   bin_i     : binary value to convert
//   busy_o    : conversion steps remain
//   done_o    : high during the final step; bcd_o is valid the following cycle
//   bcd_o     : DIGITS packed BCD nibbles, units in [3:0]
// One conversion step per cycle, VAL_W steps total. Carries out of the top
// nibble are dropped, so values above 10^DIGITS-1 produce meaningless BCD;
// the caller is expected to detect that range itself.
module bin2bcd_serial #(
  parameter int VAL_W  = 8,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [VAL_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DIGITS*4-1:0]   bcd_o
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == CNT_W'(1));
  assign bcd_o  = bcd_q;

  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
    end

    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = CNT_W'(VAL_W);
    end else if (busy_o) begin
      bcd_d = {adj[BCD_W-2:0], bin_q[VAL_W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-channel seven-segment display controller.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : seg_display_ctrl_if.slave (val/blank/blink_en in; seg/upd_done/upd_chan out)
// Channels are converted round-robin through one shared serial BCD engine
// (LOAD 1 cycle, SHIFT VAL_W cycles, COMMIT 1 cycle). Each commit writes a
// per-channel display register with overflow dashes and leading-zero
// blanking applied. seg is re-registered every cycle from the display
// registers, masked by blank and, when enabled, the blink phase.
// Build option: define SEG_BLINK_EN to include the blink counter; without it
// the blink phase is constant 0 and blink_en is ignored.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int N_CHAN    = 4,
  parameter int VAL_W     = 8,
  parameter int DIGITS    = 2,
  parameter int BLINK_DIV = 25000000
) (
  input  logic               clk,
  input  logic               reset,
  seg_display_ctrl_if.slave  bus
);

  localparam int          CH_W    = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int          CHAN_W  = DIGITS * 7;
  localparam int          BCD_W   = DIGITS * 4;
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS - 1);

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        ptr_q, ptr_d;
  logic                   ovf_q, ovf_d;
  logic [VAL_W-1:0]       chan_val;
  logic                   start, busy, done;
  logic [BCD_W-1:0]       bcd;
  logic [CHAN_W-1:0]      disp_q [N_CHAN];
  logic [CHAN_W-1:0]      code_d;
  logic [3:0]             nib;
  logic                   seen;
  logic                   upd_done_q, upd_done_d;
  logic [CH_W-1:0]        upd_chan_q;
  logic [N_CHAN*CHAN_W-1:0] seg_q, seg_d;
  logic [N_CHAN-1:0]      blink_mask;

  assign chan_val     = bus.val[int'(ptr_q) * VAL_W +: VAL_W];
  assign bus.seg      = seg_q;
  assign bus.upd_done = upd_done_q;
  assign bus.upd_chan = upd_chan_q;

  bin2bcd_serial #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (reset),
    .start_i (start),
    .bin_i   (chan_val),
    .busy_o  (busy),
    .done_o  (done),
    .bcd_o   (bcd)
  );

  // Sequencer: the overflow flag is captured from the same sample the engine loads.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ovf_d      = ovf_q;
    start      = 1'b0;
    upd_done_d = 1'b0;
    case (state_q)
      LOAD: begin
        start   = 1'b1;
        ovf_d   = (64'(chan_val) > MAX_VAL);
        state_d = SHIFT;
      end
      SHIFT: begin
        // !busy is a defensive exit; done always arrives first in normal operation
        if (done || !busy) state_d = COMMIT;
      end
      COMMIT: begin
        upd_done_d = 1'b1;
        ptr_d      = (ptr_q == CH_W'(N_CHAN - 1)) ? '0 : ptr_q + CH_W'(1);
        state_d    = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Walk digits from the top: a digit is lit once any nonzero digit at or
  // above it has been seen; the units digit is always lit.
  always_comb begin
    code_d = '0;
    nib    = '0;
    seen   = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib = bcd[d*4 +: 4];
      if (nib != 4'd0) seen = 1'b1;
      if (ovf_q)                code_d[d*7 +: 7] = SEG_DASH;
      else if (seen || d == 0)  code_d[d*7 +: 7] = digit_to_seg(nib);
      else                      code_d[d*7 +: 7] = SEG_BLANK;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_mask = bus.blink_en & {N_CHAN{phase_q}};
`else
  localparam int unused_blink_div = BLINK_DIV;
  logic unused_blink_en;

  assign unused_blink_en = ^bus.blink_en;
  assign blink_mask      = '0;
`endif

  always_comb begin
    seg_d = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      seg_d[c*CHAN_W +: CHAN_W] = (bus.blank[c] || blink_mask[c]) ? {CHAN_W{1'b1}} : disp_q[c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD;
      ptr_q      <= '0;
      ovf_q      <= 1'b0;
      upd_done_q <= 1'b0;
      upd_chan_q <= '0;
      seg_q      <= '1;
      for (int c = 0; c < N_CHAN; c++) disp_q[c] <= {DIGITS{SEG_BLANK}};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ovf_q      <= ovf_d;
      upd_done_q <= upd_done_d;
      seg_q      <= seg_d;
      if (state_q == COMMIT) begin
        disp_q[ptr_q] <= code_d;
        upd_chan_q    <= ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
module tb_seg_display_ctrl;

  localparam int N_CHAN    = 4;
  localparam int VAL_W     = 8;
  localparam int DIGITS    = 2;
  localparam int BLINK_DIV = 4;
  localparam logic [13:0] ALL1 = 14'h3FFF;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg_display_ctrl_if #(.N_CHAN(N_CHAN), .VAL_W(VAL_W), .DIGITS(DIGITS)) bus ();

  seg_display_ctrl #(
    .N_CHAN    (N_CHAN),
    .VAL_W     (VAL_W),
    .DIGITS    (DIGITS),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          chan;
    logic [13:0] seg;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [6:0] ref_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [13:0] exp_chan(input int v);
    if (v > 99) return {7'b0111111, 7'b0111111};
    return {((v / 10) == 0) ? 7'b1111111 : ref_code(v / 10), ref_code(v % 10)};
  endfunction

  function automatic logic [13:0] ch_seg(input int c);
    return bus.seg[c*14 +: 14];
  endfunction

  task automatic wait_commit(input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.upd_done === 1'b1 && bus.upd_chan === 2'(c)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    exp_t e;
    bus.val      = {8'd42, 8'd150, 8'd7, 8'd90};
    bus.blank    = '0;
    bus.blink_en = '0;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.seg !== '1) begin
      n_fail++; $display("FAIL reset_seg: got %h want all ones", bus.seg);
    end
    n_checks++;
    if (bus.upd_done !== 1'b0 || bus.upd_chan !== 2'd0) begin
      n_fail++; $display("FAIL reset_upd: got done=%b chan=%0d want 0/0", bus.upd_done, bus.upd_chan);
    end
    sb.push_back('{0, exp_chan(90)});
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (k < 10 && (bus.upd_done !== 1'b0 || bus.seg !== '1)) begin
        n_fail++; $display("FAIL first_latency_early cyc%0d: done=%b seg=%h want done=0 seg all ones", k, bus.upd_done, bus.seg);
      end else if (k == 10 && (bus.upd_done !== 1'b1 || bus.upd_chan !== 2'd0 || bus.seg !== '1)) begin
        n_fail++; $display("FAIL first_commit: done=%b chan=%0d seg=%h want done=1 chan=0 seg all ones", bus.upd_done, bus.upd_chan, bus.seg);
      end
    end
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (ch_seg(e.chan) !== e.seg || bus.upd_done !== 1'b0) begin
      n_fail++; $display("FAIL ch0_val90: seg=%b done=%b want %b done=0", ch_seg(e.chan), bus.upd_done, e.seg);
    end
  endtask

  task automatic test_small_values;
    exp_t e;
    bit   ok;
    sb.push_back('{1, exp_chan(7)});
    wait_commit(1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ch1_commit_timeout: got none want upd_chan=1"); end
    bus.val[15:8] = 8'd0;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (ch_seg(e.chan) !== e.seg) begin
      n_fail++; $display("FAIL ch1_val7: got %b want %b", ch_seg(e.chan), e.seg);
    end
    sb.push_back('{1, exp_chan(0)});
    wait_commit(1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ch1_commit2_timeout: got none want upd_chan=1"); end
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (ch_seg(e.chan) !== e.seg) begin
      n_fail++; $display("FAIL ch1_val0: got %b want %b", ch_seg(e.chan), e.seg);
    end
  endtask

  task automatic test_overflow;
    exp_t e;
    bit   ok;
    sb.push_back('{2, exp_chan(150)});
    wait_commit(2, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ch2_commit_timeout: got none want upd_chan=2"); end
    bus.val[23:16] = 8'd99;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (ch_seg(e.chan) !== e.seg) begin
      n_fail++; $display("FAIL ch2_overflow: got %b want %b", ch_seg(e.chan), e.seg);
    end
    sb.push_back('{2, exp_chan(99)});
    wait_commit(2, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ch2_commit2_timeout: got none want upd_chan=2"); end
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (ch_seg(e.chan) !== e.seg) begin
      n_fail++; $display("FAIL ch2_val99: got %b want %b", ch_seg(e.chan), e.seg);
    end
  endtask

  task automatic test_blink;
    exp_t        e;
    bit          ok;
    logic [13:0] s [24];
    logic [13:0] v, want;
    int          t;
    v = exp_chan(42);
    sb.push_back('{3, v});
    wait_commit(3, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ch3_commit_timeout: got none want upd_chan=3"); end
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (ch_seg(e.chan) !== e.seg) begin
      n_fail++; $display("FAIL ch3_val42: got %b want %b", ch_seg(e.chan), e.seg);
    end
    bus.blink_en[3] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      s[i] = ch_seg(3);
      n_checks++;
      if (ch_seg(0) !== exp_chan(90) || ch_seg(1) !== exp_chan(0) || ch_seg(2) !== exp_chan(99)) begin
        n_fail++; $display("FAIL blink_others_steady cyc%0d: got %h want ch0..2 steady", i, bus.seg[41:0]);
      end
    end
`ifdef SEG_BLINK_EN
    t = -1;
    for (int i = 1; i < 6; i++) if (t < 0 && s[i] !== s[i-1]) t = i;
    n_checks++;
    if (t < 0) begin
      n_fail++; $display("FAIL blink_toggle: got no change in 6 cycles want toggle every 4");
    end else begin
      n_checks++;
      if (s[t] !== v && s[t] !== ALL1) begin
        n_fail++; $display("FAIL blink_pattern: got %b want %b or all ones", s[t], v);
      end
      for (int j = 0; j < 16; j++) begin
        want = (((j / 4) % 2) == 0) ? s[t] : ((s[t] === v) ? ALL1 : v);
        n_checks++;
        if (s[t+j] !== want) begin
          n_fail++; $display("FAIL blink_phase step%0d: got %b want %b", j, s[t+j], want);
        end
      end
    end
`else
    t = 0;
    for (int i = 0; i < 24; i++) begin
      n_checks++;
      if (s[i] !== v) begin
        n_fail++; $display("FAIL blink_disabled_steady cyc%0d: got %b want %b (t=%0d)", i, s[i], v, t);
      end
    end
`endif
    bus.blink_en[3] = 1'b0;
  endtask

  task automatic test_blank;
    exp_t e;
    bit   ok;
    wait_commit(0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ch0_commit_timeout: got none want upd_chan=0"); end
    bus.blank[0]    = 1'b1;
    bus.blink_en[0] = 1'b1;
    bus.val[7:0]    = 8'd55;
    sb.push_back('{0, exp_chan(55)});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (ch_seg(0) !== ALL1) begin
        n_fail++; $display("FAIL blank_dark cyc%0d: got %b want all ones", i, ch_seg(0));
      end
    end
    wait_commit(0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ch0_blank_commit_timeout: got none want upd_chan=0"); end
    @(negedge clk);
    n_checks++;
    if (ch_seg(0) !== ALL1) begin
      n_fail++; $display("FAIL blank_over_commit: got %b want all ones", ch_seg(0));
    end
    bus.blank[0]    = 1'b0;
    bus.blink_en[0] = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (ch_seg(e.chan) !== e.seg) begin
      n_fail++; $display("FAIL unblank_val55: got %b want %b", ch_seg(e.chan), e.seg);
    end
  endtask

  task automatic test_reset_mid_shift;
    bit ok;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    int idx;
    wait_commit(1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ch1_pre_reset_timeout: got none want upd_chan=1"); end
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.seg !== '1 || bus.upd_done !== 1'b0 || bus.upd_chan !== 2'd0) begin
      n_fail++; $display("FAIL async_reset: seg=%h done=%b chan=%0d want all ones/0/0", bus.seg, bus.upd_done, bus.upd_chan);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.upd_done !== 1'b0 || bus.seg !== '1) begin
        n_fail++; $display("FAIL reset_hold cyc%0d: done=%b seg=%h want 0/all ones", i, bus.upd_done, bus.seg);
      end
    end
    reset = 1'b0;
    idx = 0;
    for (int i = 0; i < 80 && idx < 5; i++) begin
      @(negedge clk);
      if (bus.upd_done === 1'b1) begin
        n_checks++;
        if (bus.upd_chan !== 2'(exp_seq[idx])) begin
          n_fail++; $display("FAIL restart_seq[%0d]: got %0d want %0d", idx, bus.upd_chan, exp_seq[idx]);
        end
        idx++;
      end
    end
    n_checks++;
    if (idx != 5) begin
      n_fail++; $display("FAIL restart_seq_timeout: got %0d commits want 5", idx);
    end
  endtask

  initial begin
    test_reset();
    test_small_values();
    test_overflow();
    test_blink();
    test_blank();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
